// File: rtl/acc_tag_pack_dat_1_1.sv
// Packs a shifted signed accumulator into the 20-bit tagged round/saturate word.
// Optional macro ACC_TAG_RELU_EN adds the cfg_relu input driving the neg tag (bit 19).
module acc_tag_pack_dat_1_1 #(
    parameter int ACC_WIDTH     = 32,
    parameter int SHIFT_WIDTH   = 4,
    parameter int I_0_DAT_WIDTH = 20,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ACC_WIDTH-1:0]     t_0_dat,
    input  logic                     t_0_valid,
    output logic                     t_0_ready,
    input  logic [SHIFT_WIDTH-1:0]   cfg_shift,
`ifdef ACC_TAG_RELU_EN
    input  logic                     cfg_relu,
`endif
    input  logic                     cfg_clr_cnt,
    output logic [I_0_DAT_WIDTH-1:0] i_0_dat,
    output logic                     i_0_valid,
    input  logic                     i_0_ready,
    output logic [CNT_WIDTH-1:0]     sat_cnt,
    output logic [CNT_WIDTH-1:0]     beat_cnt
);

    // Handshake: a beat moves when valid & ready are both high at a clk edge;
    // the whole pipe advances together whenever the output slot is empty or draining.
    logic en;
    assign en        = ~i_0_valid | i_0_ready;
    assign t_0_ready = en;

    logic                   s1_valid;
    logic [ACC_WIDTH-1:0]   s1_a;
    logic [SHIFT_WIDTH-1:0] s1_s;
`ifdef ACC_TAG_RELU_EN
    logic                   s1_relu;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_s     <= '0;
`ifdef ACC_TAG_RELU_EN
            s1_relu  <= 1'b0;
`endif
        end else if (en) begin
            s1_valid <= t_0_valid;
            if (t_0_valid) begin
                s1_a    <= t_0_dat;
                s1_s    <= cfg_shift;
`ifdef ACC_TAG_RELU_EN
                s1_relu <= cfg_relu;
`endif
            end
        end
    end

    logic signed [ACC_WIDTH-1:0] b;
    logic [ACC_WIDTH-16:0]       b_hi;
    logic [SHIFT_WIDTH-1:0]      s_m1;
    logic                        neg;
    logic                        pre_sat;
    logic                        rnd;
    logic [I_0_DAT_WIDTH-1:0]    packed_word;

    always_comb begin
        b           = $signed(s1_a) >>> s1_s;
        b_hi        = b[ACC_WIDTH-1:15];
        // Fits in 16 bits only when every bit from 15 upward is a copy of the sign.
        pre_sat     = ~((&b_hi) | ~(|b_hi));
        s_m1        = s1_s - SHIFT_WIDTH'(1);
        rnd         = (s1_s != '0) ? s1_a[s_m1] : 1'b0;
`ifdef ACC_TAG_RELU_EN
        neg         = s1_relu & s1_a[ACC_WIDTH-1];
`else
        neg         = 1'b0;
`endif
        packed_word = {neg, pre_sat, rnd, s1_a[ACC_WIDTH-1], b[15:0]};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            i_0_valid <= 1'b0;
            i_0_dat   <= '0;
        end else if (en) begin
            i_0_valid <= s1_valid;
            if (s1_valid) begin
                i_0_dat <= packed_word;
            end
        end
    end

    logic xfer;
    assign xfer = i_0_valid & i_0_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beat_cnt <= '0;
            sat_cnt  <= '0;
        end else if (cfg_clr_cnt) begin
            beat_cnt <= '0;
            sat_cnt  <= '0;
        end else if (xfer) begin
            if (beat_cnt != '1) begin
                beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            end
            if (i_0_dat[18] && (sat_cnt != '1)) begin
                sat_cnt <= sat_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/acc_tag_pack_dat_1_1.md
Name: acc_tag_pack_dat_1_1

Overview:
- Producer side of the 20-bit tagged round/saturate word.
- Takes a signed wide accumulator and shifts it arithmetically right by a programmable amount.
- Computes the negative, pre-saturation, rounding and sign tags, and packs them with the 16-bit data field into the word consumed by the downstream round/saturate stage.
- Sits between the MAC accumulators and the round/saturate block. It is a 2-stage, valid/ready pipeline with saturation statistics.

Parameters:
- ACC_WIDTH, 32, width of signed input accumulator (must be >= 32).
- SHIFT_WIDTH, 4, width of shift control; legal shift 0..15.
- I_0_DAT_WIDTH, 20, width of packed output word (fixed layout; must be 20).
- CNT_WIDTH, 16, width of statistics counters.

Ports:
- clk  input  1  clock.
- reset_n  input  1  synchronous active-low reset.
- t_0_dat  input  ACC_WIDTH  signed accumulator value A.
- t_0_valid  input  1  A valid.
- t_0_ready  output  1  block accepts A this cycle.
- cfg_shift  input  SHIFT_WIDTH  right-shift amount S, sampled with each accepted beat.
- cfg_relu  input  1  clamp-negative request; present only with ACC_TAG_RELU_EN.
- cfg_clr_cnt  input  1  synchronous clear of statistics counters.
- i_0_dat  output  I_0_DAT_WIDTH  packed tagged word.
- i_0_valid  output  1  i_0_dat valid.
- i_0_ready  input  1  downstream accepts i_0_dat.
- sat_cnt  output  CNT_WIDTH  count of transferred words with pre_sat=1.
- beat_cnt  output  CNT_WIDTH  count of transferred words.

Behaviour:
- Reset (reset_n=0 at clk edge):
  - all valids = 0, i_0_dat = 0, sat_cnt = 0, beat_cnt = 0.
  - t_0_ready = 1 in the cycle after reset release.
  - A reset mid-operation drops in-flight beats; nothing is emitted for them.
- Pipeline:
  - Advance enable en = ~i_0_valid | i_0_ready. t_0_ready = en (combinational).
  - Stage 1 registers A and S, plus cfg_relu under the macro, on t_0_valid & en.
  - Stage 2 registers the packed word on en.
  - Latency 2 cycles from accept to i_0_valid. Full throughput of 1 word/cycle while i_0_ready = 1.
  - When en = 0 all stages hold.
  - i_0_dat and i_0_valid are stable while i_0_valid & ~i_0_ready.
  - Bubbles propagate: stage valid = previous stage valid when en.
- Arithmetic, computed at full ACC_WIDTH:
  - B = A >>> S (sign-extending).
  - bit19 neg = see Optional Feature.
  - bit18 pre_sat = 1 iff B[ACC_WIDTH-1:15] not all equal, i.e. B outside [-32768, 32767].
  - bit17 round = A[S-1] when S > 0, else 0.
  - bit16 sign = A[ACC_WIDTH-1].
  - bits15:0 = B[15:0] (wraps when pre_sat = 1; consumer saturates by sign).
- Counters:
  - Increment only on transfer (i_0_valid & i_0_ready): beat_cnt += 1; sat_cnt += 1 if bit18.
  - Both saturate at all-ones (no wrap).
  - cfg_clr_cnt has priority over a simultaneous increment; result is 0.
- S is latched per beat. A cfg_shift change affects only beats accepted after the change.

Optional Feature:
- Macro ACC_TAG_RELU_EN.
- Defined:
  - cfg_relu port exists and is staged with the beat.
  - bit19 = cfg_relu & A[ACC_WIDTH-1]; other fields are unchanged by it.
- Undefined:
  - cfg_relu port is absent.
  - bit19 is constant 0.

Test Plan:
- A=32'h0001_2345, S=4, i_0_ready=1 -> i_0_dat=20'h01234 two cycles after accept; beat_cnt=1, sat_cnt=0.
- A=32'h0000_0018, S=4 -> 20'h20001 (round=1).
- A=32'h0010_0000, S=4 -> 20'h40000 (pre_sat=1, sign=0); sat_cnt increments.
- A=32'hFFFF_FFF0, S=4 -> 20'h1FFFF. With ACC_TAG_RELU_EN and cfg_relu=1 -> 20'h9FFFF.
- Back-to-back 8 beats with i_0_ready low for 3 cycles mid-stream -> no loss or duplication, order preserved, output held stable while stalled, beat_cnt=8.
- reset_n pulsed low with 2 beats in flight -> no output for them; counters 0. cfg_clr_cnt asserted concurrently with a transfer -> counters read 0 next cycle.
